// File: rtl/fp_pkg.sv
// ============================================================================
// Module   : fp_pkg
// Brief    : Shared types and IEEE-754 single-precision constants for fp_mul_seq
// Revision : 1.0
// ============================================================================
`default_nettype none

package fp_pkg;

    localparam int EXP_W     = 8;
    localparam int FRAC_W    = 23;
    localparam int MANT_W    = FRAC_W + 1;
    localparam int PROD_W    = 2 * MANT_W;
    localparam int EXP_SUM_W = 10;
    localparam int BIAS      = 127;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/fp_round_pack.sv
// ============================================================================
// Module   : fp_round_pack
// Brief    : Combinational normalise, round-to-nearest-even and pack of a product
// Revision : 1.0
// ============================================================================
`default_nettype none

module fp_round_pack
    import fp_pkg::*;
(
    input  logic                        i_sign,
    input  logic signed [EXP_SUM_W-1:0] i_exp,
    input  logic [PROD_W-1:0]           i_prod,
    output logic [31:0]                 o_result
);

    logic [MANT_W-1:0]           w_mant;
    logic                        w_guard;
    logic                        w_sticky;
    logic                        w_round_up;
    logic [MANT_W:0]             w_mant_r;
    logic [FRAC_W-1:0]           w_frac;
    logic signed [EXP_SUM_W-1:0] w_exp_n;
    logic signed [EXP_SUM_W-1:0] w_exp_f;

    always_comb begin
        // Product of two [1,2) significands lies in [1,4): leading one at bit 47 or 46.
        if (i_prod[PROD_W-1]) begin
            w_mant   = i_prod[47:24];
            w_guard  = i_prod[23];
            w_sticky = |i_prod[22:0];
            w_exp_n  = i_exp + 10'sd1;
        end else begin
            w_mant   = i_prod[46:23];
            w_guard  = i_prod[22];
            w_sticky = |i_prod[21:0];
            w_exp_n  = i_exp;
        end

        w_round_up = w_guard & (w_sticky | w_mant[0]);
        w_mant_r   = {1'b0, w_mant} + {{MANT_W{1'b0}}, w_round_up};

        if (w_mant_r[MANT_W]) begin
            w_exp_f = w_exp_n + 10'sd1;
            w_frac  = w_mant_r[FRAC_W:1];
        end else begin
            w_exp_f = w_exp_n;
            w_frac  = w_mant_r[FRAC_W-1:0];
        end

        if (w_exp_f >= 10'sd255) begin
            o_result = {i_sign, 8'hFF, {FRAC_W{1'b0}}};
        end else if (w_exp_f <= 10'sd0) begin
            o_result = {i_sign, 31'd0};
        end else begin
            o_result = {i_sign, w_exp_f[EXP_W-1:0], w_frac};
        end
    end

endmodule

`default_nettype wire

// File: rtl/fp_mul_seq.sv
// ============================================================================
// Module   : fp_mul_seq
// Brief    : Sequential single-precision multiplier, 24-cycle shift-add core
// Revision : 1.0
// ============================================================================
`default_nettype none

module fp_mul_seq
    import fp_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in1,
    input  logic [DATA_WIDTH-1:0] in2,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out
);

    state_t                      r_state_q, w_state_d;
    logic [4:0]                  r_cnt_q, w_cnt_d;
    logic [MANT_W-1:0]           r_ma_q, w_ma_d;
    logic [PROD_W-1:0]           r_prod_q, w_prod_d;
    logic                        r_sign_q, w_sign_d;
    logic signed [EXP_SUM_W-1:0] r_exp_q, w_exp_d;
    logic                        r_spec_q, w_spec_d;
    logic [31:0]                 r_spec_val_q, w_spec_val_d;
    logic [31:0]                 r_out_q, w_out_d;

    logic [EXP_W-1:0]            w_e1, w_e2;
    logic [FRAC_W-1:0]           w_f1, w_f2;
    logic                        w_sign;
    logic                        w_nan1, w_nan2, w_inf1, w_inf2, w_zero1, w_zero2;
    logic [EXP_SUM_W-1:0]        w_exp_sum;
    logic [MANT_W:0]             w_sum;
    logic [31:0]                 w_packed;

    assign w_e1   = in1[30:23];
    assign w_e2   = in2[30:23];
    assign w_f1   = in1[22:0];
    assign w_f2   = in2[22:0];
    assign w_sign = in1[31] ^ in2[31];

    // Denormal inputs are flushed: any zero exponent counts as zero.
    assign w_nan1  = (w_e1 == 8'hFF) && (w_f1 != '0);
    assign w_nan2  = (w_e2 == 8'hFF) && (w_f2 != '0);
    assign w_inf1  = (w_e1 == 8'hFF) && (w_f1 == '0);
    assign w_inf2  = (w_e2 == 8'hFF) && (w_f2 == '0);
    assign w_zero1 = (w_e1 == 8'h00);
    assign w_zero2 = (w_e2 == 8'h00);

    assign w_exp_sum = {2'b00, w_e1} + {2'b00, w_e2} - 10'(BIAS);

    // One shift-add step: conditionally add the multiplicand to the upper half, shift right.
    assign w_sum = {1'b0, r_prod_q[PROD_W-1:MANT_W]}
                 + (r_prod_q[0] ? {1'b0, r_ma_q} : {(MANT_W+1){1'b0}});

    fp_round_pack u_round_pack (
        .i_sign   (r_sign_q),
        .i_exp    (r_exp_q),
        .i_prod   (r_prod_q),
        .o_result (w_packed)
    );

    always_comb begin
        w_state_d    = r_state_q;
        w_cnt_d      = r_cnt_q;
        w_ma_d       = r_ma_q;
        w_prod_d     = r_prod_q;
        w_sign_d     = r_sign_q;
        w_exp_d      = r_exp_q;
        w_spec_d     = r_spec_q;
        w_spec_val_d = r_spec_val_q;
        w_out_d      = r_out_q;

        case (r_state_q)
            IDLE: begin
                if (in_valid) begin
                    w_ma_d    = {1'b1, w_f1};
                    w_prod_d  = {{MANT_W{1'b0}}, 1'b1, w_f2};
                    w_sign_d  = w_sign;
                    w_exp_d   = w_exp_sum;
                    w_cnt_d   = 5'd0;
                    w_state_d = MUL;
                    w_spec_d  = 1'b1;
                    if (w_nan1 || w_nan2 || (w_inf1 && w_zero2) || (w_zero1 && w_inf2)) begin
                        w_spec_val_d = QNAN;
                    end else if (w_inf1 || w_inf2) begin
                        w_spec_val_d = POS_INF | {w_sign, 31'd0};
                    end else if (w_zero1 || w_zero2) begin
                        w_spec_val_d = {w_sign, 31'd0};
                    end else begin
                        w_spec_d     = 1'b0;
                        w_spec_val_d = 32'd0;
                    end
                end
            end
            MUL: begin
                w_prod_d = {w_sum, r_prod_q[MANT_W-1:1]};
                if (r_cnt_q == 5'd23) begin
                    w_cnt_d   = 5'd0;
                    w_state_d = NORM;
                end else begin
                    w_cnt_d = r_cnt_q + 5'd1;
                end
            end
            NORM: begin
                w_out_d   = r_spec_q ? r_spec_val_q : w_packed;
                w_state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    w_state_d = IDLE;
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q    <= IDLE;
            r_cnt_q      <= '0;
            r_ma_q       <= '0;
            r_prod_q     <= '0;
            r_sign_q     <= 1'b0;
            r_exp_q      <= '0;
            r_spec_q     <= 1'b0;
            r_spec_val_q <= '0;
            r_out_q      <= '0;
        end else begin
            r_state_q    <= w_state_d;
            r_cnt_q      <= w_cnt_d;
            r_ma_q       <= w_ma_d;
            r_prod_q     <= w_prod_d;
            r_sign_q     <= w_sign_d;
            r_exp_q      <= w_exp_d;
            r_spec_q     <= w_spec_d;
            r_spec_val_q <= w_spec_val_d;
            r_out_q      <= w_out_d;
        end
    end

    assign in_ready  = (r_state_q == IDLE);
    assign out_valid = (r_state_q == DONE);
    assign out       = r_out_q;

endmodule

`default_nettype wire

// File: tb/tb_fp_mul_seq.sv
// ============================================================================
// Module   : tb_fp_mul_seq
// Brief    : Scoreboard bench for fp_mul_seq with a real-arithmetic reference
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fp_mul_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in1;
    logic [31:0] in2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic        prev_ov  = 1'b0;

    logic [31:0] q_exp[$];
    int          q_acc[$];

    fp_mul_seq #(.DATA_WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in1       (in1),
        .in2       (in2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Independent model: exact product in double precision, rounded by value.
    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        logic   s;
        int     ea, eb, ex;
        longint fa, fb, mi;
        real    m, fl, fr;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        fa = longint'(a[22:0]);
        fb = longint'(b[22:0]);
        if ((ea == 255 && fa != 0) || (eb == 255 && fb != 0)) return 32'h7FC00000;
        if ((ea == 255 && eb == 0) || (eb == 255 && ea == 0)) return 32'h7FC00000;
        if (ea == 255 || eb == 255) return {s, 8'hFF, 23'h0};
        if (ea == 0 || eb == 0) return {s, 31'h0};
        m  = real'(fa + 64'd8388608) * real'(fb + 64'd8388608) / 8388608.0;
        ex = ea + eb - 127;
        while (m >= 16777216.0) begin
            m  = m / 2.0;
            ex = ex + 1;
        end
        fl = $floor(m);
        fr = m - fl;
        mi = longint'(fl);
        if (fr > 0.5 || (fr == 0.5 && mi[0])) mi = mi + 1;
        if (mi == 64'd16777216) begin
            mi = mi >> 1;
            ex = ex + 1;
        end
        if (ex >= 255) return {s, 8'hFF, 23'h0};
        if (ex <= 0) return {s, 31'h0};
        return {s, ex[7:0], mi[22:0]};
    endfunction

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("send_timeout", 32'(in_ready), 32'd1);
            return;
        end
        in_valid = 1'b1;
        in1      = a;
        in2      = b;
        q_exp.push_back(exp);
        q_acc.push_back(cyc + 1);
        @(negedge clk);
        in_valid = 1'b0;
        in1      = $urandom;
        in2      = $urandom;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (q_exp.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(q_exp.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        #1;
        if (!rst) begin
            if (out_valid && !prev_ov) begin
                if (q_acc.size() == 0) check("spurious_valid", 32'd1, 32'd0);
                else check("latency", 32'(cyc - q_acc[0]), 32'd25);
            end
            if (out_valid && out_ready && q_exp.size() != 0) begin
                check("result", out, q_exp.pop_front());
                void'(q_acc.pop_front());
            end
        end
        prev_ov = out_valid;
    end

    initial begin
        logic [31:0] dir_a[11] = '{32'h40000000, 32'h3FC00000, 32'h3F800001, 32'h80000000,
                                   32'h7F800000, 32'h7F000000, 32'h00800000, 32'h7FC00001,
                                   32'h7F800000, 32'h00000001, 32'hBF800000};
        logic [31:0] dir_b[11] = '{32'h40400000, 32'h3FC00000, 32'h3F800001, 32'h3F800000,
                                   32'h00000000, 32'h7F000000, 32'h00800000, 32'h3F800000,
                                   32'hC0000000, 32'h3F800000, 32'h3F800000};
        logic [31:0] dir_e[11] = '{32'h40C00000, 32'h40100000, 32'h3F800002, 32'h80000000,
                                   32'h7FC00000, 32'h7F800000, 32'h00000000, 32'h7FC00000,
                                   32'hFF800000, 32'h00000000, 32'hBF800000};
        logic [31:0] a, b;
        int          n;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in1       = '0;
        in2       = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out", out, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            send(dir_a[i], dir_b[i], dir_e[i]);
            wait_drain();
        end

        // Backpressure: result held in DONE while new requests are presented.
        out_ready = 1'b0;
        send(32'h40000000, 32'h40400000, 32'h40C00000);
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("bp_valid_seen", 32'(out_valid), 32'd1);
        for (int i = 0; i < 10; i++) begin
            check("bp_out", out, 32'h40C00000);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            in_valid = 1'b1;
            in1      = 32'h3F800000;
            in2      = 32'h40800000;
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_idle", 32'(in_ready), 32'd1);
        check("bp_drained", 32'(q_exp.size()), 32'd0);
        send(32'h3FC00000, 32'h3FC00000, 32'h40100000);
        wait_drain();

        // Reset roughly ten cycles into the shift-add phase.
        send(32'h3F800000, 32'h40000000, 32'h40000000);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        q_exp.delete();
        q_acc.delete();
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_out", out, 32'h0);
        repeat (40) @(negedge clk);
        send(32'h40000000, 32'h40400000, 32'h40C00000);
        wait_drain();

        for (int i = 0; i < 1200; i++) begin
            a = $urandom;
            b = $urandom;
            if (i % 4 != 0) begin
                a[30:23] = 8'($urandom_range(154, 100));
                b[30:23] = 8'($urandom_range(154, 100));
            end
            send(a, b, ref_mul(a, b));
        end
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
